// File: rtl/oc8051_cxrom_pkg.sv
// rtl/oc8051_cxrom_pkg.sv - shared cxrom port widths and byte-lane layout
package oc8051_cxrom_pkg;

  localparam int CXROM_ADDR_W         = 16;
  localparam int CXROM_WORD_W         = 32;
  localparam int CXROM_BYTES_PER_WORD = 4;

  // Lane n of a ROM word holds the byte at cxrom_addr + n.
  localparam int CXROM_LANE0_LSB = 0;
  localparam int CXROM_LANE1_LSB = 8;
  localparam int CXROM_LANE2_LSB = 16;
  localparam int CXROM_LANE3_LSB = 24;

  function automatic logic [7:0] cxrom_lane(input logic [CXROM_WORD_W-1:0] word, input int lane);
    return word[lane*8 +: 8];
  endfunction

endpackage

// File: rtl/oc8051_byte_fifo.sv
// rtl/oc8051_byte_fifo.sv - circular byte queue, 4-byte push, 0-3 byte pop, 3-byte head window
module oc8051_byte_fifo
  import oc8051_cxrom_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    wr_en,
  input  logic [CXROM_WORD_W-1:0] wr_data,
  input  logic [1:0]              rd_take,
  output logic [$clog2(DEPTH):0]  count,
  output logic [23:0]             head
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + (wr_en ? AW'(CXROM_BYTES_PER_WORD) : '0);
      rptr  <= rptr + AW'(rd_take);
      count <= count - (AW+1)'(rd_take) + (wr_en ? (AW+1)'(CXROM_BYTES_PER_WORD) : '0);
    end
  end

  // Storage needs no reset: bytes beyond count are masked out of the window.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < CXROM_BYTES_PER_WORD; i++) begin
        mem[wptr + AW'(i)] <= cxrom_lane(wr_data, i);
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_head
    assign head[8*g +: 8] = (count > (AW+1)'(g)) ? mem[rptr + AW'(g)] : 8'h00;
  end

endmodule

// File: rtl/oc8051_cxrom_fetch.sv
// rtl/oc8051_cxrom_fetch.sv - cxrom prefetch unit presenting a 3-byte instruction window
module oc8051_cxrom_fetch
  import oc8051_cxrom_pkg::*;
#(
  parameter int                      DEPTH    = 8,
  parameter logic [CXROM_ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [CXROM_ADDR_W-1:0] cxrom_addr,
  input  logic [CXROM_WORD_W-1:0] cxrom_data_in,
  input  logic                    redir_valid,
  input  logic [CXROM_ADDR_W-1:0] redir_addr,
  input  logic [1:0]              take,
  output logic [23:0]             out_data,
  output logic [1:0]              out_count,
  output logic [CXROM_ADDR_W-1:0] out_pc,
  output logic                    take_err
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]           count;
  logic [CXROM_ADDR_W-1:0] fptr;
  logic [CXROM_ADDR_W-1:0] rd_pc;
  logic [1:0]              take_eff;
  logic [CW:0]             need;
  logic                    fetch;

  assign out_count = (count >= CW'(3)) ? 2'd3 : count[1:0];
  assign take_eff  = (take > out_count) ? out_count : take;

  // Fetch only if the whole ROM word fits after this cycle's consumption.
  assign need  = {1'b0, count} - (CW+1)'(take_eff) + (CW+1)'(CXROM_BYTES_PER_WORD);
  assign fetch = !redir_valid && (need <= (CW+1)'(DEPTH));

  oc8051_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (redir_valid),
    .wr_en   (fetch),
    .wr_data (cxrom_data_in),
    .rd_take (take_eff),
    .count   (count),
    .head    (out_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      fptr     <= RESET_PC;
      rd_pc    <= RESET_PC;
      take_err <= 1'b0;
    end else if (redir_valid) begin
      fptr  <= redir_addr;
      rd_pc <= redir_addr;
    end else begin
      if (fetch) fptr <= fptr + CXROM_ADDR_W'(CXROM_BYTES_PER_WORD);
      rd_pc <= rd_pc + CXROM_ADDR_W'(take_eff);
      if (take > out_count) take_err <= 1'b1;
    end
  end

  assign cxrom_addr = fptr;
  assign out_pc     = rd_pc;

endmodule

// File: tb/tb_oc8051_cxrom_fetch.sv
// tb/tb_oc8051_cxrom_fetch.sv - scoreboard bench for oc8051_cxrom_fetch against a low-byte ROM image
module tb_oc8051_cxrom_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cxrom_addr;
  logic [31:0] cxrom_data_in;
  logic        redir_valid;
  logic [15:0] redir_addr;
  logic [1:0]  take;
  logic [23:0] out_data;
  logic [1:0]  out_count;
  logic [15:0] out_pc;
  logic        take_err;

  oc8051_cxrom_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .cxrom_addr    (cxrom_addr),
    .cxrom_data_in (cxrom_data_in),
    .redir_valid   (redir_valid),
    .redir_addr    (redir_addr),
    .take          (take),
    .out_data      (out_data),
    .out_count     (out_count),
    .out_pc        (out_pc),
    .take_err      (take_err)
  );

  always #5 clk = ~clk;

  // ROM image: every byte equals the low 8 bits of its address
  logic [15:0] a1, a2, a3;
  assign a1 = cxrom_addr + 16'd1;
  assign a2 = cxrom_addr + 16'd2;
  assign a3 = cxrom_addr + 16'd3;
  assign cxrom_data_in = {a3[7:0], a2[7:0], a1[7:0], cxrom_addr[7:0]};

  typedef struct {
    int          cyc;
    string       name;
    logic [15:0] addr;
    logic [1:0]  cnt;
    logic [23:0] data;
    logic [15:0] pc;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc_cnt = 0;
  int   n_pass  = 0;
  int   n_total = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [23:0] win(input logic [15:0] p);
    logic [15:0] p1, p2;
    p1 = p + 16'd1;
    p2 = p + 16'd2;
    return {p2[7:0], p1[7:0], p[7:0]};
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
      e = sb.pop_front();
      chk({e.name, "_cyc"},   cyc_cnt,               e.cyc);
      chk({e.name, "_addr"},  {16'h0, cxrom_addr},   {16'h0, e.addr});
      chk({e.name, "_count"}, {30'h0, out_count},    {30'h0, e.cnt});
      chk({e.name, "_data"},  {8'h0, out_data},      {8'h0, e.data});
      chk({e.name, "_pc"},    {16'h0, out_pc},       {16'h0, e.pc});
      chk({e.name, "_err"},   {31'h0, take_err},     {31'h0, e.err});
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input string nm, input logic r, input logic [1:0] tk, input logic rv,
                      input logic [15:0] ra, input logic [15:0] ea, input logic [1:0] ec,
                      input logic [23:0] ed, input logic [15:0] ep, input logic ee);
    exp_t x;
    rst         = r;
    take        = tk;
    redir_valid = rv;
    redir_addr  = ra;
    x.cyc  = cyc_cnt + 1;
    x.name = nm;
    x.addr = ea;
    x.cnt  = ec;
    x.data = ed;
    x.pc   = ep;
    x.err  = ee;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  int t3_addr [6] = '{8, 12, 16, 20, 20, 24};

  initial begin
    rst         = 1'b0;
    take        = 2'd3;
    redir_valid = 1'b1;
    redir_addr  = 16'h5555;
    @(posedge clk);
    #1;
    step("rst0",  1'b0, 2'd3, 1'b1, 16'h5555, 16'h0000, 2'd0, 24'h000000, 16'h0000, 1'b0);
    step("rst1",  1'b0, 2'd3, 1'b1, 16'h5555, 16'h0000, 2'd0, 24'h000000, 16'h0000, 1'b0);
    step("fill1", 1'b1, 2'd0, 1'b0, 16'h0000, 16'h0004, 2'd3, 24'h020100, 16'h0000, 1'b0);
    step("fill2", 1'b1, 2'd0, 1'b0, 16'h0000, 16'h0008, 2'd3, 24'h020100, 16'h0000, 1'b0);
    step("full",  1'b1, 2'd0, 1'b0, 16'h0000, 16'h0008, 2'd3, 24'h020100, 16'h0000, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step($sformatf("take3_%0d", k), 1'b1, 2'd3, 1'b0, 16'h0000, 16'(t3_addr[k]), 2'd3,
           win(16'(3*(k+1))), 16'(3*(k+1)), 1'b0);
    end
    step("take2",    1'b1, 2'd2, 1'b0, 16'h0000, 16'h001C, 2'd3, 24'h161514, 16'h0014, 1'b0);
    step("redir_t1", 1'b1, 2'd2, 1'b1, 16'h1234, 16'h1234, 2'd0, 24'h000000, 16'h1234, 1'b0);
    step("redir_t2", 1'b1, 2'd0, 1'b0, 16'h0000, 16'h1238, 2'd3, 24'h363534, 16'h1234, 1'b0);
    step("wrap_r",   1'b1, 2'd0, 1'b1, 16'hFFFE, 16'hFFFE, 2'd0, 24'h000000, 16'hFFFE, 1'b0);
    step("wrap_f",   1'b1, 2'd0, 1'b0, 16'h0000, 16'h0002, 2'd3, 24'h00FFFE, 16'hFFFE, 1'b0);
    step("wrap1",    1'b1, 2'd1, 1'b0, 16'h0000, 16'h0006, 2'd3, 24'h0100FF, 16'hFFFF, 1'b0);
    step("wrap2",    1'b1, 2'd1, 1'b0, 16'h0000, 16'h0006, 2'd3, 24'h020100, 16'h0000, 1'b0);
    step("wrap3",    1'b1, 2'd1, 1'b0, 16'h0000, 16'h0006, 2'd3, 24'h030201, 16'h0001, 1'b0);
    step("wrap4",    1'b1, 2'd1, 1'b0, 16'h0000, 16'h000A, 2'd3, 24'h040302, 16'h0002, 1'b0);
    step("mid_rst",  1'b0, 2'd3, 1'b0, 16'h0000, 16'h0000, 2'd0, 24'h000000, 16'h0000, 1'b0);
    step("restart",  1'b1, 2'd0, 1'b0, 16'h0000, 16'h0004, 2'd3, 24'h020100, 16'h0000, 1'b0);
    step("rst2",     1'b0, 2'd0, 1'b0, 16'h0000, 16'h0000, 2'd0, 24'h000000, 16'h0000, 1'b0);
    step("empty_tk", 1'b1, 2'd3, 1'b0, 16'h0000, 16'h0004, 2'd3, 24'h020100, 16'h0000, 1'b1);
    step("err_hold", 1'b1, 2'd0, 1'b0, 16'h0000, 16'h0008, 2'd3, 24'h020100, 16'h0000, 1'b1);
    step("err_redir",1'b1, 2'd0, 1'b1, 16'h0040, 16'h0040, 2'd0, 24'h000000, 16'h0040, 1'b1);
    redir_valid = 1'b0;
    take        = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
